// File: rtl/reset_sequencer.sv
// reset_sequencer: async-assert / sync-release reset generator with staggered domain release and software partial reset
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int N_DOMAINS   = 4,
    parameter int STAGGER     = 4,
    parameter int SW_PULSE    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sw_rst,
    input  logic [N_DOMAINS-1:0] i_sw_mask,
    output logic [N_DOMAINS-1:0] o_rst_n,
    output logic                 o_rst_ah,
    output logic                 o_ready
);
    localparam int MAX_A = HOLD_CYCLES > STAGGER ? HOLD_CYCLES : STAGGER;
    localparam int MAX_C = MAX_A > SW_PULSE ? MAX_A : SW_PULSE;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam int IW    = $clog2(N_DOMAINS) + 1;

    typedef enum logic [2:0] {RESET, HOLD, RELEASE, RUN, SWRST} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [N_DOMAINS-1:0]   r_mask;
    logic                   w_cnt_zero;
    logic [N_DOMAINS-1:0]   w_idx_bit;

    assign w_cnt_zero = r_cnt == '0;
    assign w_idx_bit  = N_DOMAINS'(1) << r_idx;
    assign o_rst_ah   = ~o_rst_n[0];

    // Deassertion synchroniser: clears instantly on raw reset, fills with ones afterwards
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end

    // Sequencing FSM: hold, staggered release, then run with optional masked software pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RESET;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_mask  <= '0;
            o_rst_n <= '0;
            o_ready <= 1'b0;
        end else begin
            case (r_state)
                RESET: begin
                    if (r_sync[SYNC_STAGES-1]) begin
                        r_state <= HOLD;
                        r_cnt   <= CW'(HOLD_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (w_cnt_zero) begin
                        o_rst_n[0] <= 1'b1;
                        if (N_DOMAINS == 1) begin
                            o_ready <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            r_state <= RELEASE;
                            r_cnt   <= CW'(STAGGER - 1);
                            r_idx   <= IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RELEASE: begin
                    if (w_cnt_zero) begin
                        o_rst_n <= o_rst_n | w_idx_bit;
                        if (r_idx == IW'(N_DOMAINS - 1)) begin
                            o_ready <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            r_cnt <= CW'(STAGGER - 1);
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (i_sw_rst && |i_sw_mask) begin
                        r_mask  <= i_sw_mask;
                        o_rst_n <= o_rst_n & ~i_sw_mask;
                        o_ready <= 1'b0;
                        r_cnt   <= CW'(SW_PULSE - 1);
                        r_state <= SWRST;
                    end
                end
                SWRST: begin
                    if (w_cnt_zero) begin
                        o_rst_n <= o_rst_n | r_mask;
                        o_ready <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for two reset_sequencer configurations against a timing-rule reference model
module tb_reset_sequencer;
    logic       clk       = 1'b0;
    logic       i_rst_n   = 1'b1;
    logic       i_sw_rst  = 1'b0;
    logic [3:0] i_sw_mask = 4'b0;
    logic [3:0] rst0;
    logic       ah0, rdy0;
    logic [0:0] rst1;
    logic       ah1, rdy1;

    int checks = 0;
    int errors = 0;

    int p_hc[2] = '{16, 1};
    int p_nd[2] = '{4, 1};
    int p_sp[2] = '{8, 1};

    int         e[2];
    int         swe[2];
    logic [3:0] swm[2];
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    always #5 clk = ~clk;

    reset_sequencer u_dut0 (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_sw_rst(i_sw_rst), .i_sw_mask(i_sw_mask),
        .o_rst_n(rst0), .o_rst_ah(ah0), .o_ready(rdy0)
    );

    reset_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .N_DOMAINS(1), .STAGGER(4), .SW_PULSE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_sw_rst(i_sw_rst), .i_sw_mask(i_sw_mask[0]),
        .o_rst_n(rst1), .o_rst_ah(ah1), .o_ready(rdy1)
    );

    // Expected {rst_ah, ready, rst_n} after edge ee, given last accepted software request at edge se
    function automatic logic [5:0] expv(int m, int ee, int se, logic [3:0] sm);
        int   t0;
        logic [3:0] r;
        logic insw, rdy;
        t0 = 2 + p_hc[m] + 1;
        r  = 4'b0;
        for (int k = 0; k < p_nd[m]; k++) r[k] = ee >= t0 + k * 4;
        insw = ee > 0 && ee >= se && ee < se + p_sp[m];
        if (insw) r = r & ~sm;
        rdy = ee >= t0 + (p_nd[m] - 1) * 4 && !insw;
        return {~r[0], rdy, r};
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            e[m]   = 0;
            swe[m] = -1000;
            swm[m] = 4'b0;
        end
    endtask

    task automatic medge();
        if (!i_rst_n) mreset();
        else begin
            for (int m = 0; m < 2; m++) begin
                logic [3:0] mk;
                logic [5:0] v;
                mk = (m == 1) ? {3'b0, i_sw_mask[0]} : i_sw_mask;
                v  = expv(m, e[m], swe[m], swm[m]);
                e[m]++;
                if (v[4] && i_sw_rst && mk != 4'b0) begin
                    swe[m] = e[m];
                    swm[m] = mk;
                end
            end
        end
    endtask

    // pulse: 0 none, 1 drop reset mid-cycle and release before next edge, 2 drop and keep low
    task automatic cyc(input logic sw, input logic [3:0] mk, input int pulse);
        i_sw_rst  = sw;
        i_sw_mask = mk;
        @(posedge clk);
        medge();
        #2;
        if (pulse != 0) begin
            i_rst_n = 1'b0;
            mreset();
        end
        #1;
        q0.push_back(expv(0, e[0], swe[0], swm[0]));
        q1.push_back(expv(1, e[1], swe[1], swm[1]));
        if (pulse == 1) begin
            #4;
            i_rst_n = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] x;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                x = q0.pop_front();
                checks++;
                if ({ah0, rdy0, rst0} !== x) begin
                    errors++;
                    $display("FAIL dut0 t=%0t got ah/rdy/rst_n=%b expected %b", $time, {ah0, rdy0, rst0}, x);
                end
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                checks++;
                if ({ah1, rdy1, 3'b000, rst1} !== x) begin
                    errors++;
                    $display("FAIL dut1 t=%0t got ah/rdy/rst_n=%b expected %b", $time, {ah1, rdy1, 3'b000, rst1}, x);
                end
            end
        end
    end

    initial begin
        int r;
        mreset();
        #1 i_rst_n = 1'b0;
        repeat (4) cyc(1'b0, 4'b0, 2);
        cyc(1'b0, 4'b0, 1);
        repeat (35) cyc(1'b0, 4'b0, 0);
        cyc(1'b1, 4'b0110, 0);
        cyc(1'b0, 4'b0, 0);
        cyc(1'b1, 4'b0001, 0);
        repeat (10) cyc(1'b0, 4'b0, 0);
        cyc(1'b1, 4'b0000, 0);
        repeat (2) cyc(1'b0, 4'b0, 0);
        cyc(1'b1, 4'b1000, 0);
        repeat (10) cyc(1'b0, 4'b0, 0);
        cyc(1'b0, 4'b0, 1);
        repeat (24) cyc(1'b0, 4'b0, 0);
        cyc(1'b0, 4'b0, 1);
        repeat (40) cyc(1'b0, 4'b0, 0);
        repeat (500) begin
            r = $urandom_range(0, 149);
            cyc($urandom_range(0, 2) == 0, 4'($urandom), (r == 0) ? 1 : 0);
        end
        repeat (40) cyc(1'b0, 4'b0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
